// File: rtl/debug_overlay_sched.sv
// Debug overlay sequencer: per-frame snapshot strobe, debug page selection and
// periodic temperature-sensor measurement scheduling with timeout supervision.
module debug_overlay_sched #(
  parameter int NPAGES          = 4,
  parameter int FRAMES_PER_PAGE = 64,
  parameter int MEAS_PERIOD     = 128,
  parameter int MEAS_TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        freeze,
  input  logic        next_page,
  input  logic        auto_cycle,
  input  logic        meas_done,
  output logic [3:0]  page,
  output logic        snap_strobe,
  output logic        meas_trigger,
  output logic        meas_busy,
  output logic        meas_valid,
  output logic        meas_timeout,
  output logic [6:0]  frame_cnt
);

  localparam int FW = $clog2(FRAMES_PER_PAGE + 1);
  localparam int PW = $clog2(MEAS_PERIOD);
  localparam int TW = $clog2(MEAS_TIMEOUT);

  localparam logic [3:0]    PAGE_MAX = 4'(NPAGES - 1);
  localparam logic [FW-1:0] PF_MAX   = FW'(FRAMES_PER_PAGE - 1);
  localparam logic [PW-1:0] PER_MAX  = PW'(MEAS_PERIOD - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(MEAS_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_TRIG = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic          fs_s;
  logic          elapse_s;
  logic [3:0]    page_inc_s;
  logic [6:0]    frame_q, frame_d;
  logic          snap_q, snap_d;
  logic [3:0]    page_q, page_d;
  logic [FW-1:0] pf_q, pf_d;
  logic [PW-1:0] per_q, per_d;
  logic [1:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          trig_q, trig_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          tout_q, tout_d;

  assign fs_s       = clken && (hc == 11'd0) && (vc == 11'd0);
  assign elapse_s   = fs_s && (per_q == PER_MAX);
  assign page_inc_s = (page_q == PAGE_MAX) ? 4'd0 : page_q + 4'd1;

  always_comb begin
    frame_d = fs_s ? frame_q + 7'd1 : frame_q;
    snap_d  = fs_s && !freeze;
    per_d   = per_q;
    if (fs_s) begin
      per_d = (per_q == PER_MAX) ? '0 : per_q + PW'(1);
    end else begin
      per_d = per_q;
    end
  end

  // Manual advance beats the automatic one; a frozen overlay ignores both.
  always_comb begin
    page_d = page_q;
    pf_d   = pf_q;
    if (!freeze && next_page) begin
      page_d = page_inc_s;
      pf_d   = '0;
    end else if (!freeze && auto_cycle && fs_s) begin
      if (pf_q == PF_MAX) begin
        page_d = page_inc_s;
        pf_d   = '0;
      end else begin
        pf_d = pf_q + FW'(1);
      end
    end else begin
      pf_d = pf_q;
    end
  end

  // tcnt counts clocks since the trigger cycle, so TO_MAX is the last busy cycle.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tcnt_d  = tcnt_q + TW'(1);
    valid_d = valid_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        tcnt_d  = '0;
        state_d = elapse_s ? S_TRIG : S_IDLE;
      end
      S_PEND: begin
        tcnt_d  = '0;
        state_d = S_TRIG;
      end
      S_TRIG: begin
        state_d = S_WAIT;
        pend_d  = pend_q || elapse_s;
      end
      S_WAIT: begin
        if (meas_done || (tcnt_q == TO_MAX)) begin
          if (meas_done) begin
            valid_d = 1'b1;
            tout_d  = 1'b0;
          end else begin
            tout_d = 1'b1;
          end
          state_d = (pend_q || elapse_s) ? S_PEND : S_IDLE;
          pend_d  = 1'b0;
        end else begin
          pend_d = pend_q || elapse_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase
    trig_d = (state_d == S_TRIG);
    busy_d = (state_d == S_TRIG) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 7'd0;
      snap_q  <= 1'b0;
      page_q  <= 4'd0;
      pf_q    <= '0;
      per_q   <= '0;
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      tcnt_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      snap_q  <= snap_d;
      page_q  <= page_d;
      pf_q    <= pf_d;
      per_q   <= per_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      tcnt_q  <= tcnt_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  assign page         = page_q;
  assign snap_strobe  = snap_q;
  assign meas_trigger = trig_q;
  assign meas_busy    = busy_q;
  assign meas_valid   = valid_q;
  assign meas_timeout = tout_q;
  assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_debug_overlay_sched.sv
// Bench for debug_overlay_sched: directed frame/page/measurement scenarios plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_debug_overlay_sched;

  localparam int NP  = 4;
  localparam int FPP = 2;
  localparam int MP  = 2;
  localparam int MT  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clken = 1'b0;
  logic [10:0] hc = 11'd0;
  logic [10:0] vc = 11'd0;
  logic        freeze = 1'b0;
  logic        next_page = 1'b0;
  logic        auto_cycle = 1'b0;
  logic        meas_done = 1'b0;
  logic [3:0]  page;
  logic        snap_strobe, meas_trigger, meas_busy, meas_valid, meas_timeout;
  logic [6:0]  frame_cnt;

  debug_overlay_sched #(
    .NPAGES(NP), .FRAMES_PER_PAGE(FPP), .MEAS_PERIOD(MP), .MEAS_TIMEOUT(MT)
  ) dut (
    .clk(clk), .rst(rst), .clken(clken), .hc(hc), .vc(vc),
    .freeze(freeze), .next_page(next_page), .auto_cycle(auto_cycle),
    .meas_done(meas_done), .page(page), .snap_strobe(snap_strobe),
    .meas_trigger(meas_trigger), .meas_busy(meas_busy), .meas_valid(meas_valid),
    .meas_timeout(meas_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a measurement is "in flight" with an age in clocks since its trigger.
  int m_page = 0, m_pfc = 0, m_frame = 0, m_per = 0, m_age = 0;
  bit m_snap = 0, m_busy = 0, m_req = 0, m_gap = 0;
  bit m_valid = 0, m_tout = 0, m_trig = 0, m_fs = 0, m_el = 0;

  bit resp_en = 0;
  int resp_cd = 0;
  int spur_div = 0;
  int snaps = 0, trigs = 0, busy_cycles = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_page = 0; m_pfc = 0; m_frame = 0; m_per = 0; m_age = 0;
      m_snap = 0; m_busy = 0; m_req = 0; m_gap = 0;
      m_valid = 0; m_tout = 0; m_trig = 0;
    end else begin
      m_fs = clken && (hc == 11'd0) && (vc == 11'd0);
      m_el = m_fs && (m_per == MP - 1);
      if (m_fs) begin
        m_frame = (m_frame + 1) % 128;
        m_per   = (m_per + 1) % MP;
      end
      m_snap = m_fs && !freeze;
      if (!freeze && next_page) begin
        m_page = (m_page + 1) % NP;
        m_pfc  = 0;
      end else if (!freeze && auto_cycle && m_fs) begin
        if (m_pfc == FPP - 1) begin
          m_page = (m_page + 1) % NP;
          m_pfc  = 0;
        end else begin
          m_pfc = m_pfc + 1;
        end
      end
      if (m_busy) begin
        if (m_el) m_req = 1;
        if (m_age >= 1 && meas_done) begin
          m_valid = 1; m_tout = 0; m_busy = 0; m_gap = m_req; m_req = 0;
        end else if (m_age == MT - 1) begin
          m_tout = 1; m_busy = 0; m_gap = m_req; m_req = 0;
        end else begin
          m_age = m_age + 1;
        end
      end else if (m_gap) begin
        m_gap = 0; m_busy = 1; m_age = 0;
      end else if (m_el) begin
        m_busy = 1; m_age = 0;
      end
      m_trig = m_busy && (m_age == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("page", int'(page), m_page);
    chk("snap_strobe", int'(snap_strobe), int'(m_snap));
    chk("meas_trigger", int'(meas_trigger), int'(m_trig));
    chk("meas_busy", int'(meas_busy), int'(m_busy));
    chk("meas_valid", int'(meas_valid), int'(m_valid));
    chk("meas_timeout", int'(meas_timeout), int'(m_tout));
    chk("frame_cnt", int'(frame_cnt), m_frame);
    if (snap_strobe) snaps++;
    if (meas_trigger) trigs++;
    if (meas_busy) busy_cycles++;
    if (meas_trigger && resp_en) resp_cd = $urandom_range(11, 1);
  endtask

  // One clock of stimulus: frame start or a near-miss timing value, then compare.
  task automatic cyc(input bit fs_b, input bit np_b);
    next_page = np_b;
    if (fs_b) begin
      clken = 1'b1; hc = 11'd0; vc = 11'd0;
    end else begin
      case ($urandom_range(3, 0))
        0: begin clken = 1'b0; hc = 11'd0; vc = 11'd0; end
        1: begin clken = 1'b1; hc = 11'd0; vc = 11'($urandom_range(2047, 1)); end
        2: begin clken = 1'b1; hc = 11'($urandom_range(2047, 1)); vc = 11'd0; end
        default: begin
          clken = 1'($urandom_range(1, 0));
          hc = 11'($urandom_range(2047, 1));
          vc = 11'($urandom);
        end
      endcase
    end
    meas_done = 1'b0;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) meas_done = 1'b1;
    end
    if (spur_div != 0 && $urandom_range(spur_div - 1, 0) == 0) meas_done = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int rec;
  int fdiv;

  initial begin
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b0;
    chk("rst_page", int'(page), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_busy", int'(meas_busy), 0);
    chk("rst_valid", int'(meas_valid), 0);

    // Three frames, sensor silent: one trigger on frame 2, then a timeout.
    snaps = 0; trigs = 0; busy_cycles = 0;
    repeat (2) cyc(1'b0, 1'b0);
    repeat (3) begin
      cyc(1'b1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0);
    end
    repeat (12) cyc(1'b0, 1'b0);
    chk("three_frames_snaps", snaps, 3);
    chk("three_frames_cnt", int'(frame_cnt), 3);
    chk("one_trigger", trigs, 1);
    chk("timeout_busy_len", busy_cycles, MT);
    chk("timeout_flag", int'(meas_timeout), 1);
    chk("timeout_no_valid", int'(meas_valid), 0);
    chk("page_static", int'(page), 0);

    // Automatic page cycling with a 2-frame dwell, then a manual advance.
    resp_en = 1; auto_cycle = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rec = int'(page);
      cyc(1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
      chk("auto_seq", rec, seq[i]);
    end
    cyc(1'b0, 1'b1);
    chk("np_page", int'(page), 1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("np_restart_1", int'(page), 1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("np_restart_2", int'(page), 2);

    // Frozen overlay: no strobes, page pinned, frame counter still runs.
    freeze = 1'b1; snaps = 0;
    repeat (5) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
    end
    chk("freeze_snaps", snaps, 0);
    chk("freeze_page", int'(page), 2);
    chk("freeze_frame_cnt", int'(frame_cnt), 19);
    freeze = 1'b0;

    // Randomized traffic with varying frame-start density.
    spur_div = 32;
    for (int blk = 0; blk < 6; blk++) begin
      fdiv = $urandom_range(12, 2);
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(63, 0) == 0) freeze = ~freeze;
        if ($urandom_range(127, 0) == 0) auto_cycle = ~auto_cycle;
        cyc($urandom_range(fdiv - 1, 0) == 0, $urandom_range(15, 0) == 0);
      end
    end

    // Asynchronous reset in the middle of a measurement.
    freeze = 1'b0; spur_div = 0;
    for (int i = 0; i < 200; i++) begin
      cyc((i % 3) == 0, 1'b0);
      if (meas_busy) break;
    end
    chk("busy_before_rst", int'(meas_busy), 1);
    clken = 1'b0; next_page = 1'b0; meas_done = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_page", int'(page), 0);
    chk("arst_snap", int'(snap_strobe), 0);
    chk("arst_trig", int'(meas_trigger), 0);
    chk("arst_busy", int'(meas_busy), 0);
    chk("arst_valid", int'(meas_valid), 0);
    chk("arst_timeout", int'(meas_timeout), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    check_all();
    rst = 1'b0; resp_cd = 0; trigs = 0;
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    chk("no_trig_after_rst", trigs, 0);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("first_trig_after_rst", trigs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
